// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: EX-stage sequencer for the external multiplier and divider.
// Owns the HI/LO registers, stalls the pipeline while a multiply or divide
// is in flight, and answers MFHI/MFLO reads combinationally.
module muldiv_ctrl #(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [3:0]  op_i,
    input  logic [31:0] src_a_i,
    input  logic [31:0] src_b_i,
    output logic        stall_o,
    output logic [31:0] rdata_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic [31:0] mul_a_o,
    output logic [31:0] mul_b_o,
    output logic        mul_signed_o,
    input  logic [63:0] mul_result_i,
    output logic [31:0] div_a_o,
    output logic [31:0] div_b_o,
    output logic        div_signed_o,
    output logic        div_start_o,
    output logic        div_annul_o,
    input  logic        div_ready_i,
    input  logic [63:0] div_result_i
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    // The counter only has to hold MUL_LAT-1, so clog2(MUL_LAT) bits suffice.
    localparam int CNT_W = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_LAT - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_WAIT = 2'd1,
        DIV_WAIT = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      mul_a_q, mul_a_d;
    logic [31:0]      mul_b_q, mul_b_d;
    logic             mul_signed_q, mul_signed_d;
    logic [31:0]      div_a_q, div_a_d;
    logic [31:0]      div_b_q, div_b_d;
    logic             div_signed_q, div_signed_d;

    logic is_mul;
    logic is_div;
    logic accept;

    // Decode the EX operation; acceptance ignores stall_i because the op must
    // start even while the rest of the pipeline is frozen.
    always_comb begin
        is_mul = (op_i == OP_MULT) || (op_i == OP_MULTU);
        is_div = (op_i == OP_DIV) || (op_i == OP_DIVU);
        accept = (state_q == IDLE) && (is_mul || is_div) && !flush_i;
    end

    // Next-state logic: sequencing, operand latching and HI/LO updates.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        mul_a_d      = mul_a_q;
        mul_b_d      = mul_b_q;
        mul_signed_d = mul_signed_q;
        div_a_d      = div_a_q;
        div_b_d      = div_b_q;
        div_signed_d = div_signed_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    mul_a_d      = src_a_i;
                    mul_b_d      = src_b_i;
                    div_a_d      = src_a_i;
                    div_b_d      = src_b_i;
                    mul_signed_d = (op_i == OP_MULT) || (op_i == OP_DIV);
                    div_signed_d = (op_i == OP_MULT) || (op_i == OP_DIV);
                    if (is_mul) begin
                        state_d = MUL_WAIT;
                        cnt_d   = CNT_INIT;
                    end else if (src_b_i == 32'd0) begin
                        state_d = DONE;
                    end else begin
                        state_d = DIV_WAIT;
                    end
                end else if (!flush_i && !stall_i) begin
                    if (op_i == OP_MTHI) begin
                        hi_d = src_a_i;
                    end
                    if (op_i == OP_MTLO) begin
                        lo_d = src_a_i;
                    end
                end
            end
            MUL_WAIT: begin
                if (flush_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    hi_d    = mul_result_i[63:32];
                    lo_d    = mul_result_i[31:0];
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DIV_WAIT: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else if (div_ready_i) begin
                    hi_d    = div_result_i[63:32];
                    lo_d    = div_result_i[31:0];
                    state_d = DONE;
                end
            end
            DONE: begin
                if (flush_i || !stall_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and architectural registers, cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            mul_signed_q <= 1'b0;
            div_a_q      <= '0;
            div_b_q      <= '0;
            div_signed_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            mul_signed_q <= mul_signed_d;
            div_a_q      <= div_a_d;
            div_b_q      <= div_b_d;
            div_signed_q <= div_signed_d;
        end
    end

    // Pipeline/divider handshake outputs and the MFHI/MFLO read port.
    always_comb begin
        stall_o     = accept || (state_q == MUL_WAIT) || (state_q == DIV_WAIT);
        div_start_o = (state_q == DIV_WAIT) && !flush_i;
        div_annul_o = (state_q == DIV_WAIT) && flush_i;
        rdata_o     = 32'd0;
        if (op_i == OP_MFHI) begin
            rdata_o = hi_q;
        end else if (op_i == OP_MFLO) begin
            rdata_o = lo_q;
        end
    end

    assign hi_o         = hi_q;
    assign lo_o         = lo_q;
    assign mul_a_o      = mul_a_q;
    assign mul_b_o      = mul_b_q;
    assign mul_signed_o = mul_signed_q;
    assign div_a_o      = div_a_q;
    assign div_b_o      = div_b_q;
    assign div_signed_o = div_signed_q;

endmodule
